led_frame_scheduler: RTL and testbench
======================================

# led_frame_scheduler

Double-buffered frame store and scan sequencer for the 8x8 red/green LED matrix. Two requesters write into a hidden back buffer: game logic on port G, overlay/score on port O. A one-cycle arbiter grants one row write per cycle. The block also generates the row-scan cadence. The front buffer feeds the matrix driver's red/green array inputs. Front and back are exchanged only at a frame boundary, after the last row has been scanned, so the display never shows a torn frame.

## Interface
Parameters:
- SCAN_DIV, 4096, clock cycles per displayed row (≥2)

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high; clears all state
- g_valid  in  1  game write request
- g_ready  out  1  game write accepted this cycle
- g_row  in  3  target row 0-7
- g_red, g_green  in  8 each  row bitmaps
- o_valid, o_ready, o_row, o_red, o_green  same as G, overlay port
- swap_req  in  1  pulse: request front/back exchange at next frame boundary
- swap_pending  out  1  swap requested, not yet performed
- swap_done  out  1  one-cycle pulse in the cycle after the exchange
- scan_tick  out  1  one-cycle pulse; clock enable for the driver's row counter
- scan_row  out  3  row currently being displayed
- red_array, green_array  out  8x8 packed  front buffer, [row][column]

## Operation
- Reset: both buffers all zero; scan_row=0; divider=0; scan_tick=0; swap_pending=0; swap_done=0; round-robin pointer favours G; g_ready=o_ready=0.
- Scan: the divider counts 0..SCAN_DIV-1. scan_tick=1 in the cycle the divider equals SCAN_DIV-1. On that tick, scan_row increments mod 8, wrapping 7→0.
- Frame boundary = scan_tick asserted while scan_row==7.
- Arbitration (combinational ready, registered pointer):
  - If swap_pending=1, both readies are 0.
  - Otherwise, if only one port is valid, it is granted.
  - If both are valid, the port named by the pointer is granted; the pointer then flips to the other port.
  - A grant to a lone requester also sets the pointer to the other port.
- Write: a granted port updates back[row] red and green at the clock edge. The front buffer is never written directly. A write to a row overwrites any earlier write to that row.
- Swap FSM, states IDLE and PENDING:
  - IDLE→PENDING on swap_req.
  - PENDING→IDLE on frame boundary. At that edge front and back are exchanged, so the back buffer now holds the old front. swap_done pulses in the following cycle.
  - swap_req while PENDING is ignored; no second swap is queued.
- swap_pending is the registered PENDING state. A write granted in the same cycle as swap_req is completed before the swap.

## Timing
- Write latency: the back buffer is updated 1 cycle after grant. Its contents are invisible until the swap.
- Swap latency: from swap_req until the next frame boundary whose cycle comes after the cycle of the request.
  - swap_req coincident with a frame boundary waits a full frame (8·SCAN_DIV cycles).
- red_array/green_array are registered and change on the edge ending the boundary cycle. The driver, enabled by that same scan_tick, shows row 0 of the new frame.
- Reset mid-PENDING: the swap is abandoned, both buffers are cleared, and swap_done does not pulse.
- Back-to-back swaps: after swap_done, a swap_req in that same cycle re-enters PENDING.

## Structure
- Shared package led_pkg:
  - typedef frame_t = logic [7:0][7:0]
  - typedef row_idx_t = logic [2:0]
  - localparam NUM_ROWS=8
  - swap FSM enum {IDLE, PENDING}
- Sub-module led_scan_timer holds the divider, scan_tick and scan_row, with parameter SCAN_DIV.
- The top level holds the arbiter, the two frame_t buffer registers, a one-bit front-select and the swap FSM.
  - Swapping by toggling front-select with muxed outputs is equivalent to a physical exchange and is preferred.

## Test plan
Each scenario runs with SCAN_DIV=4.
- Reset: after two cycles of reset=1, all outputs are zero, scan_row=0, and scan_tick first pulses 4 cycles after reset release.
- Single write + swap:
  - Stimulus: G writes row 6 = red 8'b11001111, then swap_req.
  - Response: red_array[6] stays 0 until the boundary edge, then reads 8'b11001111. swap_done pulses once. The back buffer, if written to another row and swapped again, shows the old front contents.
- Contention: G and O are both valid for 4 cycles. Grants go G,O,G,O, and the final back row value is the last granted port's data.
- Swap stall: swap_req mid-frame with g_valid held high. g_ready=0 until swap_done, then g_ready=1 on the next cycle.
- Boundary coincidence: swap_req in the exact cycle of scan_row=7 with scan_tick. The exchange occurs 32 cycles later, not immediately.
- Reset mid-PENDING: swap_req, then reset before the boundary. No swap_done, and red_array/green_array stay 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types for the LED matrix frame scheduler: frame storage, row index and swap FSM states.
package led_pkg;

   localparam int unsigned NUM_ROWS = 8;

   typedef logic [NUM_ROWS-1:0][7:0] frame_t;
   typedef logic [2:0]               row_idx_t;

   typedef enum logic {
      StIdle,
      StPending
   } swap_state_e;

endpackage

// File: rtl/led_scan_timer.sv
// Row-scan cadence: a divider that pulses scan_tick once per SCAN_DIV cycles and advances the
// displayed row on each tick.
module led_scan_timer
   import led_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4096
) (
   input  logic     clock,
   input  logic     reset,
   output logic     scan_tick,
   output row_idx_t scan_row
);

   localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

   logic [DivW-1:0] div_q, div_d;
   row_idx_t        row_q, row_d;

   always_comb begin
      scan_tick = (div_q == DivLast);
      div_d     = div_q + 1'b1;
      row_d     = row_q;
      if (scan_tick) begin
         div_d = '0;
         row_d = row_q + 3'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         div_q <= '0;
         row_q <= '0;
      end else begin
         div_q <= div_d;
         row_q <= row_d;
      end
   end

   assign scan_row = row_q;

endmodule

// File: rtl/led_frame_scheduler.sv
// Double-buffered 8x8 red/green frame store: round-robin row writes into the back buffer and a
// front/back exchange deferred to the frame boundary so the display never tears.
module led_frame_scheduler
   import led_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4096
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       g_valid,
   output logic       g_ready,
   input  row_idx_t   g_row,
   input  logic [7:0] g_red,
   input  logic [7:0] g_green,
   input  logic       o_valid,
   output logic       o_ready,
   input  row_idx_t   o_row,
   input  logic [7:0] o_red,
   input  logic [7:0] o_green,
   input  logic       swap_req,
   output logic       swap_pending,
   output logic       swap_done,
   output logic       scan_tick,
   output row_idx_t   scan_row,
   output frame_t     red_array,
   output frame_t     green_array
);

   swap_state_e state_q, state_d;
   logic        front_sel_q, front_sel_d;
   logic        ptr_o_q, ptr_o_d;
   logic        swap_done_q, swap_done_d;
   frame_t      red_a_q, red_a_d, red_b_q, red_b_d;
   frame_t      green_a_q, green_a_d, green_b_q, green_b_d;

   logic       frame_boundary;
   logic       wr_en;
   row_idx_t   wr_row;
   logic [7:0] wr_red, wr_green;

   led_scan_timer #(
      .SCAN_DIV(SCAN_DIV)
   ) u_scan_timer (
      .clock    (clock),
      .reset    (reset),
      .scan_tick(scan_tick),
      .scan_row (scan_row)
   );

   assign frame_boundary = scan_tick && (scan_row == 3'd7);

   // Arbiter: ptr_o_q set means the overlay port wins the next contention.
   always_comb begin
      g_ready = 1'b0;
      o_ready = 1'b0;
      if (!reset && state_q == StIdle) begin
         if (g_valid && (!o_valid || !ptr_o_q)) begin
            g_ready = 1'b1;
         end else if (o_valid) begin
            o_ready = 1'b1;
         end
      end
      ptr_o_d = ptr_o_q;
      if (g_ready) begin
         ptr_o_d = 1'b1;
      end else if (o_ready) begin
         ptr_o_d = 1'b0;
      end
   end

   always_comb begin
      wr_en    = g_ready || o_ready;
      wr_row   = g_ready ? g_row   : o_row;
      wr_red   = g_ready ? g_red   : o_red;
      wr_green = g_ready ? g_green : o_green;
   end

   // Back buffer is A when front_sel_q is set, B otherwise.
   always_comb begin
      red_a_d   = red_a_q;
      red_b_d   = red_b_q;
      green_a_d = green_a_q;
      green_b_d = green_b_q;
      if (wr_en) begin
         if (front_sel_q) begin
            red_a_d[wr_row]   = wr_red;
            green_a_d[wr_row] = wr_green;
         end else begin
            red_b_d[wr_row]   = wr_red;
            green_b_d[wr_row] = wr_green;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      front_sel_d = front_sel_q;
      swap_done_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (swap_req) begin
               state_d = StPending;
            end
         end
         StPending: begin
            if (frame_boundary) begin
               state_d     = StIdle;
               front_sel_d = ~front_sel_q;
               swap_done_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         front_sel_q <= 1'b0;
         ptr_o_q     <= 1'b0;
         swap_done_q <= 1'b0;
         red_a_q     <= '0;
         red_b_q     <= '0;
         green_a_q   <= '0;
         green_b_q   <= '0;
      end else begin
         state_q     <= state_d;
         front_sel_q <= front_sel_d;
         ptr_o_q     <= ptr_o_d;
         swap_done_q <= swap_done_d;
         red_a_q     <= red_a_d;
         red_b_q     <= red_b_d;
         green_a_q   <= green_a_d;
         green_b_q   <= green_b_d;
      end
   end

   assign swap_pending = (state_q == StPending);
   assign swap_done    = swap_done_q;
   assign red_array    = front_sel_q ? red_b_q   : red_a_q;
   assign green_array  = front_sel_q ? green_b_q : green_a_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench for led_frame_scheduler with SCAN_DIV=4, using a frame-position and
// explicit front/back array model.
module tb_led_frame_scheduler;
   import led_pkg::*;

   localparam int unsigned SD    = 4;
   localparam int unsigned FRAME = 8 * SD;

   logic       clock = 1'b0;
   logic       reset;
   logic       g_valid, g_ready, o_valid, o_ready;
   row_idx_t   g_row, o_row;
   logic [7:0] g_red, g_green, o_red, o_green;
   logic       swap_req, swap_pending, swap_done, scan_tick;
   row_idx_t   scan_row;
   frame_t     red_array, green_array;

   int nchecks = 0;
   int nerrors = 0;

   // Reference model: cycle count since reset, pending flag, pointer, explicit front/back arrays.
   int unsigned m_t;
   logic        m_pending, m_done, m_ptr_o;
   logic [7:0]  m_fr[8], m_fg[8], m_br[8], m_bg[8];

   led_frame_scheduler #(
      .SCAN_DIV(SD)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .g_valid     (g_valid),
      .g_ready     (g_ready),
      .g_row       (g_row),
      .g_red       (g_red),
      .g_green     (g_green),
      .o_valid     (o_valid),
      .o_ready     (o_ready),
      .o_row       (o_row),
      .o_red       (o_red),
      .o_green     (o_green),
      .swap_req    (swap_req),
      .swap_pending(swap_pending),
      .swap_done   (swap_done),
      .scan_tick   (scan_tick),
      .scan_row    (scan_row),
      .red_array   (red_array),
      .green_array (green_array)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before 500000 time units");
      $fatal(1, "watchdog expired");
   end

   function automatic logic exp_g_ready();
      return !m_pending && g_valid && (!o_valid || !m_ptr_o);
   endfunction

   function automatic logic exp_o_ready();
      return !m_pending && o_valid && (!g_valid || m_ptr_o);
   endfunction

   function automatic frame_t exp_red();
      frame_t f;
      for (int r = 0; r < 8; r++) f[r] = m_fr[r];
      return f;
   endfunction

   function automatic frame_t exp_green();
      frame_t f;
      for (int r = 0; r < 8; r++) f[r] = m_fg[r];
      return f;
   endfunction

   task automatic model_update();
      logic       gg, og, bnd;
      logic [7:0] tmp;
      if (reset) begin
         m_t = 0; m_pending = 0; m_done = 0; m_ptr_o = 0;
         for (int r = 0; r < 8; r++) begin
            m_fr[r] = '0; m_fg[r] = '0; m_br[r] = '0; m_bg[r] = '0;
         end
      end else begin
         gg  = exp_g_ready();
         og  = exp_o_ready();
         bnd = ((m_t % FRAME) == FRAME - 1);
         if (gg) begin m_br[g_row] = g_red; m_bg[g_row] = g_green; m_ptr_o = 1; end
         if (og) begin m_br[o_row] = o_red; m_bg[o_row] = o_green; m_ptr_o = 0; end
         m_done = m_pending && bnd;
         if (m_pending && bnd) begin
            for (int r = 0; r < 8; r++) begin
               tmp = m_fr[r]; m_fr[r] = m_br[r]; m_br[r] = tmp;
               tmp = m_fg[r]; m_fg[r] = m_bg[r]; m_bg[r] = tmp;
            end
            m_pending = 0;
         end else if (swap_req) begin
            m_pending = 1;
         end
         m_t++;
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      g_valid = 0; o_valid = 0; swap_req = 0;
   endtask

   task automatic do_reset();
      reset = 1; idle_inputs();
      cyc(); cyc();
      reset = 0;
   endtask

   // Pulses swap_req for one cycle, then waits (bounded) until swap_done is seen.
   task automatic do_swap_wait(output int n);
      swap_req = 1;
      cyc();
      swap_req = 0;
      n = 1;
      #1;
      while (!swap_done && n < 100) begin
         cyc(); #1; n++;
      end
   endtask

   task automatic test_reset();
      int n;
      reset = 1; idle_inputs();
      cyc(); cyc();
      #1;
      nchecks++;
      if ({g_ready, o_ready, scan_tick, swap_pending, swap_done} !== 5'b0) begin
         nerrors++;
         $display("FAIL reset_flags: got %b required 00000",
                  {g_ready, o_ready, scan_tick, swap_pending, swap_done});
      end
      nchecks++;
      if (scan_row !== 3'd0) begin
         nerrors++; $display("FAIL reset_row: got %0d required 0", scan_row);
      end
      nchecks++;
      if (red_array !== '0 || green_array !== '0) begin
         nerrors++; $display("FAIL reset_arrays: got %h/%h required 0", red_array, green_array);
      end
      reset = 0;
      n = 0;
      #1;
      while (!scan_tick && n < 20) begin
         cyc(); #1; n++;
      end
      // Release cycle has divider 0, so the tick lands in the fourth cycle (three edges later).
      nchecks++;
      if (n != 3) begin
         nerrors++; $display("FAIL first_tick: got %0d edges required 3", n);
      end
      nchecks++;
      if (scan_row !== 3'd0) begin
         nerrors++; $display("FAIL tick_row0: got %0d required 0", scan_row);
      end
      cyc(); #1;
      nchecks++;
      if (scan_row !== 3'd1 || scan_tick !== 1'b0) begin
         nerrors++;
         $display("FAIL row_advance: got row %0d tick %b required row 1 tick 0", scan_row, scan_tick);
      end
   endtask

   task automatic test_write_swap();
      int         n;
      logic [7:0] gv;
      do_reset();
      gv = 8'($urandom);
      g_valid = 1; g_row = 3'd6; g_red = 8'b11001111; g_green = gv;
      #1;
      nchecks++;
      if (g_ready !== 1'b1) begin
         nerrors++; $display("FAIL ws_grant: got %b required 1", g_ready);
      end
      cyc();
      g_valid = 0;
      swap_req = 1;
      cyc();
      swap_req = 0;
      n = 1;
      #1;
      nchecks++;
      if (swap_pending !== 1'b1) begin
         nerrors++; $display("FAIL ws_pending: got %b required 1", swap_pending);
      end
      while (!swap_done && n < 100) begin
         nchecks++;
         if (red_array[6] !== 8'h00) begin
            nerrors++; $display("FAIL ws_hidden: got %b required 00000000", red_array[6]);
         end
         cyc(); #1; n++;
      end
      nchecks++;
      if (swap_done !== 1'b1 || red_array[6] !== 8'b11001111 || green_array[6] !== gv) begin
         nerrors++;
         $display("FAIL ws_visible: got done %b red %b green %h required 1 11001111 %h",
                  swap_done, red_array[6], green_array[6], gv);
      end
      cyc(); #1;
      nchecks++;
      if (swap_done !== 1'b0) begin
         nerrors++; $display("FAIL ws_done_once: got %b required 0", swap_done);
      end
      // Back now holds the old (empty) front: write row 2 there and swap it in.
      g_valid = 1; g_row = 3'd2; g_red = 8'hA5; g_green = 8'h5A;
      cyc();
      g_valid = 0;
      do_swap_wait(n);
      nchecks++;
      if (red_array[2] !== 8'hA5 || red_array[6] !== 8'h00 || green_array[2] !== 8'h5A) begin
         nerrors++;
         $display("FAIL ws_old_front: got r2 %h r6 %h g2 %h required A5 00 5A",
                  red_array[2], red_array[6], green_array[2]);
      end
      do_swap_wait(n);
      nchecks++;
      if (red_array[6] !== 8'b11001111 || red_array[2] !== 8'h00) begin
         nerrors++;
         $display("FAIL ws_third_swap: got r6 %b r2 %h required 11001111 00",
                  red_array[6], red_array[2]);
      end
   endtask

   task automatic test_contention();
      int         n;
      logic [7:0] last_r, last_g;
      do_reset();
      g_valid = 1; o_valid = 1; g_row = 3'd3; o_row = 3'd3;
      last_r = '0; last_g = '0;
      for (int k = 0; k < 4; k++) begin
         g_red = 8'($urandom); g_green = 8'($urandom);
         o_red = 8'($urandom); o_green = 8'($urandom);
         #1;
         nchecks++;
         if (g_ready !== ((k % 2) == 0) || o_ready !== ((k % 2) == 1)) begin
            nerrors++;
            $display("FAIL contention_%0d: got g %b o %b required g %b o %b",
                     k, g_ready, o_ready, (k % 2) == 0, (k % 2) == 1);
         end
         last_r = o_red; last_g = o_green;
         cyc();
      end
      idle_inputs();
      do_swap_wait(n);
      nchecks++;
      if (red_array[3] !== last_r || green_array[3] !== last_g) begin
         nerrors++;
         $display("FAIL contention_data: got %h/%h required %h/%h",
                  red_array[3], green_array[3], last_r, last_g);
      end
   endtask

   task automatic test_swap_stall();
      int         n;
      logic [7:0] rv;
      do_reset();
      for (int k = 0; k < 10; k++) cyc();
      rv = 8'($urandom);
      g_valid = 1; g_row = 3'($urandom); g_red = rv; g_green = ~rv;
      swap_req = 1;
      #1;
      nchecks++;
      if (g_ready !== 1'b1) begin
         nerrors++; $display("FAIL stall_same_cycle: got %b required 1", g_ready);
      end
      cyc();
      swap_req = 0;
      n = 1;
      #1;
      while (!swap_done && n < 100) begin
         nchecks++;
         if (g_ready !== 1'b0) begin
            nerrors++; $display("FAIL stall_ready: got %b required 0", g_ready);
         end
         cyc(); #1; n++;
      end
      nchecks++;
      if (swap_done !== 1'b1 || g_ready !== 1'b1) begin
         nerrors++;
         $display("FAIL stall_release: got done %b ready %b required 1 1", swap_done, g_ready);
      end
      nchecks++;
      if (red_array[g_row] !== rv || green_array[g_row] !== ~rv) begin
         nerrors++;
         $display("FAIL stall_data: got %h/%h required %h/%h",
                  red_array[g_row], green_array[g_row], rv, ~rv);
      end
      g_valid = 0;
   endtask

   task automatic test_boundary_coincide();
      int n;
      do_reset();
      n = 0;
      while ((m_t % FRAME) != FRAME - 1 && n < 100) begin
         cyc(); n++;
      end
      #1;
      nchecks++;
      if (scan_row !== 3'd7 || scan_tick !== 1'b1) begin
         nerrors++;
         $display("FAIL coincide_boundary: got row %0d tick %b required 7 1", scan_row, scan_tick);
      end
      do_swap_wait(n);
      nchecks++;
      if (n != 33 || swap_done !== 1'b1) begin
         nerrors++;
         $display("FAIL coincide_latency: got %0d edges done %b required 33 1", n, swap_done);
      end
   endtask

   task automatic test_reset_pending();
      int seen;
      do_reset();
      g_valid = 1; g_row = 3'd1; g_red = 8'($urandom) | 8'h01; g_green = 8'hFF;
      cyc();
      g_valid = 0; swap_req = 1;
      cyc();
      swap_req = 0;
      for (int k = 0; k < 5; k++) cyc();
      #1;
      nchecks++;
      if (swap_pending !== 1'b1) begin
         nerrors++; $display("FAIL rp_pending: got %b required 1", swap_pending);
      end
      reset = 1;
      cyc(); cyc();
      reset = 0;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (swap_done === 1'b1) seen++;
         cyc();
      end
      #1;
      nchecks++;
      if (seen != 0 || swap_pending !== 1'b0) begin
         nerrors++;
         $display("FAIL rp_no_swap: got done count %0d pending %b required 0 0", seen, swap_pending);
      end
      nchecks++;
      if (red_array !== '0 || green_array !== '0) begin
         nerrors++; $display("FAIL rp_arrays: got %h/%h required 0", red_array, green_array);
      end
   endtask

   task automatic test_random();
      logic [7:0] got_s, exp_s;
      do_reset();
      for (int k = 0; k < 800; k++) begin
         g_valid  = 1'($urandom_range(0, 1));
         o_valid  = 1'($urandom_range(0, 1));
         g_row    = 3'($urandom); o_row   = 3'($urandom);
         g_red    = 8'($urandom); g_green = 8'($urandom);
         o_red    = 8'($urandom); o_green = 8'($urandom);
         swap_req = ($urandom_range(0, 19) == 0);
         #1;
         got_s = {g_ready, o_ready, scan_tick, scan_row, swap_pending, swap_done};
         exp_s = {exp_g_ready(), exp_o_ready(), ((m_t % SD) == SD - 1),
                  3'((m_t % FRAME) / SD), m_pending, m_done};
         nchecks++;
         if (got_s !== exp_s) begin
            nerrors++; $display("FAIL rand_status cycle %0d: got %b required %b", k, got_s, exp_s);
         end
         nchecks++;
         if (red_array !== exp_red() || green_array !== exp_green()) begin
            nerrors++;
            $display("FAIL rand_front cycle %0d: got %h/%h required %h/%h",
                     k, red_array, green_array, exp_red(), exp_green());
         end
         cyc();
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      g_row = '0; o_row = '0; g_red = '0; g_green = '0; o_red = '0; o_green = '0;
      test_reset();
      test_write_swap();
      test_contention();
      test_swap_stall();
      test_boundary_coincide();
      test_reset_pending();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
